decode_stage_rv: RTL and testbench

- Parametrised successor to the single-issue decode stage: register file with NRD read ports, write-back bypass and a registered valid/ready decode→execute pipeline register.
- Adds flush, backpressure hold and an optional per-register pending-write scoreboard that stalls RAW hazards.
- Sits between fetch and execute; write-back feeds wb_* ports.

---
 rtl/decode_stage_rv_pkg.sv | 36 +++
 rtl/decode_stage_rv_regfile_np.sv | 47 ++++
 rtl/decode_stage_rv.sv | 155 +++++++++++++++
 tb/tb_decode_stage_rv.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_rv_pkg.sv
// Shared types for the decode stage: pipeline payload structs, register index type, zero-register index.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Port summary: none. The struct widths follow the package defaults below; decode_stage_rv
// parameters default to the same values and must stay equal to them.
package decode_stage_rv_pkg;

  localparam int XLEN_D = 64;
  localparam int NREG_D = 32;
  localparam int NRD_D  = 2;
  localparam int CTLW_D = 32;
  localparam int CNTW_D = 2;
  localparam int AW_D   = $clog2(NREG_D);

  // Architectural register 0 always reads as zero and ignores writes.
  localparam int REG_ZERO = 0;

  typedef logic [AW_D-1:0] creg_addr_t;

  typedef struct packed {
    logic [XLEN_D-1:0] pc;
    logic [31:0]       instr;
    logic [CTLW_D-1:0] ctl;
    creg_addr_t        dst;
    logic              dwen;
  } decode_in_t;

  typedef struct packed {
    logic [XLEN_D-1:0] pc;
    logic [31:0]       instr;
    logic [CTLW_D-1:0] ctl;
    creg_addr_t        dst;
    logic              dwen;
  } decode_out_t;

endpackage

// File: rtl/decode_stage_rv_regfile_np.sv
// Register file: NREG x XLEN storage, NRD combinational read ports with same-cycle write-back bypass.
// Latency: reads are combinational; a write lands on the rising edge (visible on dbg_reg after it).
// Backpressure: none; the single write port is always accepted.
// Ports: clk/reset (async, active-low); ra = NRD packed read indices, rd = NRD packed read data;
// wen/wa/wd = write port; dbg_reg = flat register image, register r at [r*XLEN +: XLEN].
module regfile_np
  import decode_stage_rv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*XLEN-1:0]  rd,
  input  logic                 wen,
  input  logic [AW-1:0]        wa,
  input  logic [XLEN-1:0]      wd,
  output logic [NREG*XLEN-1:0] dbg_reg
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else if (wen && wa != AW'(REG_ZERO)) begin
      mem[wa] <= wd;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra_k;
    assign ra_k = ra[k*AW +: AW];
    // Zero register wins over the bypass so a write-back to x0 can never leak through.
    assign rd[k*XLEN +: XLEN] = (ra_k == AW'(REG_ZERO))  ? '0 :
                                (wen && wa == ra_k)      ? wd :
                                                           mem[ra_k];
  end

  for (genvar r = 0; r < NREG; r++) begin : g_dbg
    assign dbg_reg[r*XLEN +: XLEN] = mem[r];
  end

endmodule

// File: rtl/decode_stage_rv.sv
// Decode stage: operand read with write-back bypass into a valid/ready decode->execute register.
// Latency: 1 cycle from accept to out_valid; a write-back feeds a same-cycle accept through the bypass.
// Backpressure: holds while out_valid && !out_ready; flush kills the held entry and refuses input.
// Ports: clk, reset (async, active-low); in_* fetch side (valid/ready); out_* execute side
// (valid/ready, out_src = NRD packed operands); flush; wb_* write-back port; dbg_reg register image.
// Build option: DECODE_SCOREBOARD_EN adds per-register pending-write counters that stall RAW hazards.
module decode_stage_rv
  import decode_stage_rv_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int NRD  = NRD_D,
  parameter int CTLW = CTLW_D,
  parameter int CNTW = CNTW_D,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  input  logic [CTLW-1:0]      in_ctl,
  input  logic [NRD*AW-1:0]    in_ra,
  input  logic [NRD-1:0]       in_ruse,
  input  logic [AW-1:0]        in_dst,
  input  logic                 in_dwen,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [31:0]          out_instr,
  output logic [CTLW-1:0]      out_ctl,
  output logic [AW-1:0]        out_dst,
  output logic                 out_dwen,
  output logic [NRD*XLEN-1:0]  out_src,
  input  logic                 flush,
  input  logic                 wb_wen,
  input  logic [AW-1:0]        wb_wa,
  input  logic [XLEN-1:0]      wb_wd,
  output logic [NREG*XLEN-1:0] dbg_reg
);

  logic [NRD*XLEN-1:0] src;
  decode_in_t          in_p;
  decode_out_t         out_q;
  logic                out_vld_q;
  logic [NRD*XLEN-1:0] src_q;
  logic                hazard;
  logic                accept;

  regfile_np #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .AW   (AW)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra      (in_ra),
    .rd      (src),
    .wen     (wb_wen),
    .wa      (wb_wa),
    .wd      (wb_wd),
    .dbg_reg (dbg_reg)
  );

  assign in_p = '{pc: in_pc, instr: in_instr, ctl: in_ctl, dst: in_dst, dwen: in_dwen};

  // Never looks at in_valid, so fetch may wait for ready before raising valid.
  assign in_ready = !flush && (!out_vld_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      src_q     <= '0;
    end else if (accept) begin
      out_vld_q <= 1'b1;
      out_q     <= in_p;
      src_q     <= src;
    end else if (out_ready || flush) begin
      // Payload is left stale; only the valid bit matters downstream.
      out_vld_q <= 1'b0;
    end
  end

  assign out_valid = out_vld_q;
  assign out_pc    = out_q.pc;
  assign out_instr = out_q.instr;
  assign out_ctl   = out_q.ctl;
  assign out_dst   = out_q.dst;
  assign out_dwen  = out_q.dwen;
  assign out_src   = src_q;

`ifdef DECODE_SCOREBOARD_EN
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0] cnt_q   [NREG];
  logic [CNTW-1:0] cnt_nxt [NREG];
  logic [NREG-1:0] uflow;
  logic [AW-1:0]   ra_a    [NRD];

  for (genvar k = 0; k < NRD; k++) begin : g_ra
    assign ra_a[k] = in_ra[k*AW +: AW];
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      // A pending write is harmless if its last outstanding write-back is arriving now:
      // the bypass delivers that value this cycle.
      if (in_ruse[k] && ra_a[k] != AW'(REG_ZERO) && cnt_q[ra_a[k]] != '0 &&
          !(wb_wen && wb_wa == ra_a[k] && cnt_q[ra_a[k]] == CNTW'(1)))
        hazard = 1'b1;
    end
    // A saturated counter cannot record another writer.
    if (in_dwen && in_dst != AW'(REG_ZERO) && cnt_q[in_dst] == CNT_MAX)
      hazard = 1'b1;
  end

  for (genvar r = 0; r < NREG; r++) begin : g_sb
    if (r == REG_ZERO) begin : g_zero
      assign cnt_nxt[r] = '0;
      assign uflow[r]   = 1'b0;
    end else begin : g_cnt
      logic          inc, dec, fl;
      logic [CNTW:0] up, down;
      assign inc  = accept && in_dwen && in_dst == AW'(r);
      assign dec  = wb_wen && wb_wa == AW'(r);
      // Flushing the held instruction retires its pending write without a write-back.
      assign fl   = flush && out_vld_q && out_q.dwen && out_q.dst == AW'(r);
      assign up   = {1'b0, cnt_q[r]} + (CNTW+1)'(inc);
      assign down = (CNTW+1)'(dec) + (CNTW+1)'(fl);
      assign uflow[r]   = down > up;
      assign cnt_nxt[r] = uflow[r] ? '0 : CNTW'(up - down);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_nxt[r];
    end
  end

  a_no_uflow: assert property (@(posedge clk) disable iff (!reset) uflow == '0)
    else $warning("decode_stage_rv: scoreboard counter decremented below zero, clamped");
`else
  assign hazard = 1'b0;
  wire unused_ruse = ^in_ruse;
`endif

endmodule

// File: tb/tb_decode_stage_rv.sv
module tb_decode_stage_rv;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int CTLW = 32;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [31:0]          in_instr;
  logic [CTLW-1:0]      in_ctl;
  logic [NRD*AW-1:0]    in_ra;
  logic [NRD-1:0]       in_ruse;
  logic [AW-1:0]        in_dst;
  logic                 in_dwen;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [31:0]          out_instr;
  logic [CTLW-1:0]      out_ctl;
  logic [AW-1:0]        out_dst;
  logic                 out_dwen;
  logic [NRD*XLEN-1:0]  out_src;
  logic                 flush;
  logic                 wb_wen;
  logic [AW-1:0]        wb_wa;
  logic [XLEN-1:0]      wb_wd;
  logic [NREG*XLEN-1:0] dbg_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_rv u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ctl    (in_ctl),
    .in_ra     (in_ra),
    .in_ruse   (in_ruse),
    .in_dst    (in_dst),
    .in_dwen   (in_dwen),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ctl   (out_ctl),
    .out_dst   (out_dst),
    .out_dwen  (out_dwen),
    .out_src   (out_src),
    .flush     (flush),
    .wb_wen    (wb_wen),
    .wb_wa     (wb_wa),
    .wb_wd     (wb_wd),
    .dbg_reg   (dbg_reg)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [1:0] ruse, input logic [4:0] dst, input logic dwen);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = pc[31:0] ^ 32'h0000_0013;
    in_ctl   = {16'h00C7, pc[15:0]};
    in_ra    = {ra1, ra0};
    in_ruse  = ruse;
    in_dst   = dst;
    in_dwen  = dwen;
  endtask

  task automatic wb(input logic en, input logic [4:0] wa, input logic [63:0] wd);
    wb_wen = en;
    wb_wa  = wa;
    wb_wd  = wd;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    in_ctl    = '0;
    in_ra     = '0;
    in_ruse   = '0;
    in_dst    = '0;
    in_dwen   = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    wb(1'b0, 5'd0, 64'd0);

    // Reset state.
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_src_zero", 64'(out_src == '0), 64'd1);
    chk("rst_dbg_zero", 64'(dbg_reg == '0), 64'd1);

    // First accept after release; reads of zeroed regs, x0 write ignored.
    #1 reset = 1'b1;
    offer(64'h100, 5'd0, 5'd5, 2'b11, 5'd0, 1'b0);
    wb(1'b1, 5'd0, 64'hDEAD);
    #1 chk("t1_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_pc", out_pc, 64'h100);
    chk("t1_out_instr", 64'(out_instr), 64'h113);
    chk("t1_out_ctl", 64'(out_ctl), 64'h00C7_0100);
    chk("t1_out_src_zero", 64'(out_src == '0), 64'd1);
    chk("t1_dbg_zero", 64'(dbg_reg == '0), 64'd1);

    // Same-cycle write-back bypass into operand 0.
    offer(64'h104, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0);
    wb(1'b1, 5'd3, 64'h1234);
    step();
    chk("t2_src0_bypass", out_src[63:0], 64'h1234);
    chk("t2_src1_zero", out_src[127:64], 64'd0);
    chk("t2_dbg_x3", dbg_reg[3*64 +: 64], 64'h1234);

    // Stored read path on operand 1.
    offer(64'h108, 5'd0, 5'd3, 2'b10, 5'd0, 1'b0);
    wb(1'b0, 5'd0, 64'd0);
    step();
    chk("t2_src1_stored", out_src[127:64], 64'h1234);
    chk("t2_pc", out_pc, 64'h108);

    // Backpressure: hold for 4 cycles.
    out_ready = 1'b0;
    offer(64'h200, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0);
    #1 chk("t3_in_ready_hold", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_pc", out_pc, 64'h108);
      chk("t3_hold_src1", out_src[127:64], 64'h1234);
      chk("t3_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1 chk("t3_release_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("t3_new_pc", out_pc, 64'h200);
    chk("t3_new_src0", out_src[63:0], 64'h1234);

    // Flush of a held writer to x7.
    offer(64'h300, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1);
    step();
    chk("t4_held_dst", 64'(out_dst), 64'd7);
    chk("t4_held_dwen", 64'(out_dwen), 64'd1);
    out_ready = 1'b0;
    offer(64'h304, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0);
    flush = 1'b1;
    #1 chk("t4_flush_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    chk("t4_flush_valid", 64'(out_valid), 64'd0);
    // x7 no longer pending, so a reader of x7 is not stalled.
    out_ready = 1'b1;
    offer(64'h308, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0);
    #1 chk("t4_x7_reader_ready", 64'(in_ready), 64'd1);
    step();
    chk("t4_x7_reader_pc", out_pc, 64'h308);

    // RAW hazard on x4.
    offer(64'h400, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1);
    step();
    offer(64'h404, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0);
`ifdef DECODE_SCOREBOARD_EN
    #1 chk("t5_raw_stall", 64'(in_ready), 64'd0);
    step();
    chk("t5_stall_valid", 64'(out_valid), 64'd0);
    chk("t5_still_stalled", 64'(in_ready), 64'd0);
    wb(1'b1, 5'd4, 64'h55);
    #1 chk("t5_wb_ready", 64'(in_ready), 64'd1);
    step();
    wb(1'b0, 5'd0, 64'd0);
    chk("t5_consumer_pc", out_pc, 64'h404);
    chk("t5_consumer_src0", out_src[63:0], 64'h55);
`else
    #1 chk("t5_no_stall", 64'(in_ready), 64'd1);
    step();
    chk("t5_consumer_pc", out_pc, 64'h404);
    chk("t5_consumer_src0", out_src[63:0], 64'd0);
    in_valid = 1'b0;
    wb(1'b1, 5'd4, 64'h55);
    step();
    wb(1'b0, 5'd0, 64'd0);
`endif
    chk("t5_dbg_x4", dbg_reg[4*64 +: 64], 64'h55);

    // Three writers to x9 then a fourth.
    offer(64'h500, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1);
    step();
    offer(64'h504, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1);
    step();
    offer(64'h508, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1);
    step();
    chk("t6_third_pc", out_pc, 64'h508);
    offer(64'h50C, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1);
`ifdef DECODE_SCOREBOARD_EN
    #1 chk("t6_sat_stall", 64'(in_ready), 64'd0);
    step();
    chk("t6_sat_valid", 64'(out_valid), 64'd0);
    wb(1'b1, 5'd9, 64'h99);
    #1 chk("t6_sat_wb_cycle", 64'(in_ready), 64'd0);
    step();
    wb(1'b0, 5'd0, 64'd0);
    #1 chk("t6_after_wb_ready", 64'(in_ready), 64'd1);
    step();
    chk("t6_fourth_pc", out_pc, 64'h50C);
`else
    #1 chk("t6_no_sat_stall", 64'(in_ready), 64'd1);
    step();
    chk("t6_fourth_pc", out_pc, 64'h50C);
    in_valid = 1'b0;
    wb(1'b1, 5'd9, 64'h99);
    step();
    wb(1'b0, 5'd0, 64'd0);
    offer(64'h50C, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0);
    step();
`endif
    chk("t6_dbg_x9", dbg_reg[9*64 +: 64], 64'h99);
    chk("t6_valid_before_rst", 64'(out_valid), 64'd1);

    // Asynchronous reset mid-operation, between clock edges.
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("t7_async_valid", 64'(out_valid), 64'd0);
    chk("t7_async_pc", out_pc, 64'd0);
    chk("t7_async_dbg_zero", 64'(dbg_reg == '0), 64'd1);
    #2 reset = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
